// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants and counter types for the 640x480 row-mask scanout.
// The DEF_* values are the default porch/sync widths; the derived constants
// give the line/frame totals and the inclusive sync windows for that mode.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;                          // 656
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;                        // 751
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;                          // 490
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;                        // 491

    typedef logic [9:0] hcnt_t;
    typedef logic [9:0] vcnt_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Horizontal/vertical pixel counters with sync and active-area decode.
// All decode outputs are combinational views of the *current* counters so the
// consumer can register them on the same clk_en edge that advances the counters.
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   clk_en       pixel tick; counters advance only when high
//   hcnt         current horizontal count
//   line_swap    this tick wraps the line and the next line is visible
//   frame_swap   line_swap whose next line is line 0
//   act          current position is inside the visible area
//   hs_n, vs_n   active-low sync decode of the current position
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clk_en,
    output hcnt_t hcnt,
    output logic  line_swap,
    output logic  frame_swap,
    output logic  act,
    output logic  hs_n,
    output logic  vs_n
);

    localparam hcnt_t H_LAST = hcnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam hcnt_t H_ACT  = hcnt_t'(H_ACTIVE);
    localparam hcnt_t HS_B   = hcnt_t'(H_ACTIVE + H_FP);
    localparam hcnt_t HS_E   = hcnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam vcnt_t V_LAST = vcnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam vcnt_t V_ACT  = vcnt_t'(V_ACTIVE);
    localparam vcnt_t VS_B   = vcnt_t'(V_ACTIVE + V_FP);
    localparam vcnt_t VS_E   = vcnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    hcnt_t hcnt_q, hcnt_d;
    vcnt_t vcnt_q, vcnt_d;
    vcnt_t vcnt_nxt;
    logic  h_wrap;

    // Next-state counters plus decode of the current position.
    always_comb begin
        h_wrap   = (hcnt_q == H_LAST);
        vcnt_nxt = vcnt_q;
        if (h_wrap) begin
            if (vcnt_q == V_LAST) begin
                vcnt_nxt = '0;
            end else begin
                vcnt_nxt = vcnt_q + 10'd1;
            end
        end else begin
            vcnt_nxt = vcnt_q;
        end

        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (clk_en) begin
            if (h_wrap) begin
                hcnt_d = '0;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
            vcnt_d = vcnt_nxt;
        end else begin
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
        end

        // The swap loads the row for the line that starts after this tick.
        line_swap  = clk_en && h_wrap && (vcnt_nxt < V_ACT);
        frame_swap = line_swap && (vcnt_nxt == '0);
        act        = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_n       = !((hcnt_q >= HS_B) && (hcnt_q <= HS_E));
        vs_n       = !((vcnt_q >= VS_B) && (vcnt_q <= VS_E));
    end

    // Counter registers; reset parks on the last position so the first tick swaps line 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= H_LAST;
            vcnt_q <= V_LAST;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt = hcnt_q;

endmodule

// File: rtl/mask_scanout_vga.sv
// mask_scanout_vga
// Consumer end of the row-mask interface. Double-buffers 640-bit row masks
// (back buffer filled by rp_valid, front buffer scanned out) and serialises
// the front row under VGA timing.
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   clk_en        pixel tick
//   mg_mask       row mask, bit 0 = leftmost pixel; valid with rp_valid
//   rp_valid      one-cycle row strobe (independent of clk_en)
//   row_req       back buffer empty, ready for a row (registered level)
//   frame_start   one-cycle pulse at the line 0 swap
//   pix_on, de    pixel bit and data enable
//   hsync, vsync  active-low syncs
//   underrun      sticky: a visible line started with no row ready
//   dropped       sticky: a row arrived while the back buffer was full
module mask_scanout_vga
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic [0:H_ACTIVE-1] mg_mask,
    input  logic                rp_valid,
    output logic                row_req,
    output logic                frame_start,
    output logic                pix_on,
    output logic                de,
    output logic                hsync,
    output logic                vsync,
    output logic                underrun,
    output logic                dropped
);

    hcnt_t hcnt;
    logic  line_swap;
    logic  frame_swap;
    logic  act;
    logic  hs_n;
    logic  vs_n;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .hcnt       (hcnt),
        .line_swap  (line_swap),
        .frame_swap (frame_swap),
        .act        (act),
        .hs_n       (hs_n),
        .vs_n       (vs_n)
    );

    logic [0:H_ACTIVE-1] front_q, front_d;
    logic [0:H_ACTIVE-1] back_q, back_d;
    logic [0:H_ACTIVE-1] pix_sh;
    logic                back_full_q, back_full_d;
    logic                underrun_q, underrun_d;
    logic                dropped_q, dropped_d;
    logic                row_req_q, row_req_d;
    logic                frame_start_q, frame_start_d;
    logic                pix_on_q, pix_on_d;
    logic                de_q, de_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;

    // Buffer capture/swap, sticky flags and output next-state.
    always_comb begin
        front_d     = front_q;
        back_d      = back_q;
        back_full_d = back_full_q;
        underrun_d  = underrun_q;
        dropped_d   = dropped_q;

        if (line_swap) begin
            if (back_full_q) begin
                front_d = back_q;
                // A row arriving on the swap edge refills the slot just vacated.
                if (rp_valid) begin
                    back_d      = mg_mask;
                    back_full_d = 1'b1;
                end else begin
                    back_full_d = 1'b0;
                end
            end else if (rp_valid) begin
                // Row arrived exactly at its deadline: go straight to the front.
                front_d = mg_mask;
            end else begin
                front_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (rp_valid) begin
            if (back_full_q) begin
                dropped_d = 1'b1;
            end else begin
                back_d      = mg_mask;
                back_full_d = 1'b1;
            end
        end else begin
            back_full_d = back_full_q;
        end

        row_req_d     = !back_full_q;
        frame_start_d = frame_swap;

        // front_q[hcnt] via a shift; index 0 is the MSB of an ascending range.
        pix_sh = front_q << hcnt;

        if (clk_en) begin
            de_d    = act;
            pix_on_d = act ? pix_sh[0] : 1'b0;
            hsync_d = hs_n;
            vsync_d = vs_n;
        end else begin
            de_d     = de_q;
            pix_on_d = pix_on_q;
            hsync_d  = hsync_q;
            vsync_d  = vsync_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_q       <= '0;
            back_q        <= '0;
            back_full_q   <= 1'b0;
            underrun_q    <= 1'b0;
            dropped_q     <= 1'b0;
            row_req_q     <= 1'b0;
            frame_start_q <= 1'b0;
            pix_on_q      <= 1'b0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
        end else begin
            front_q       <= front_d;
            back_q        <= back_d;
            back_full_q   <= back_full_d;
            underrun_q    <= underrun_d;
            dropped_q     <= dropped_d;
            row_req_q     <= row_req_d;
            frame_start_q <= frame_start_d;
            pix_on_q      <= pix_on_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign row_req     = row_req_q;
    assign frame_start = frame_start_q;
    assign pix_on      = pix_on_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign underrun    = underrun_q;
    assign dropped     = dropped_q;

endmodule

// File: doc/mask_scanout_vga.md
# mask_scanout_vga

Consumer end of the row-mask interface. Accepts 640-bit row masks from the mask generator via the `rp_valid` strobe and double-buffers them. Serialises each row pixel-by-pixel under standard 640x480 VGA timing, producing the pixel, sync and data-enable outputs. Drives a row-request level back to the generator and flags rows that arrive too late.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- clk_en  in  1  pixel tick; counters and outputs advance only when high.
- mg_mask  in  [0:H_ACTIVE-1]  row mask; bit 0 is the leftmost pixel.
- rp_valid  in  1  one-cycle strobe; mg_mask is valid in that cycle.
- row_req  out  1  level; back buffer empty, ready for a row.
- frame_start  out  1  one-cycle pulse at the swap for line 0.
- pix_on  out  1  current pixel mask bit.
- de  out  1  data enable; high for active pixels.
- hsync  out  1  active-low.
- vsync  out  1  active-low.
- underrun  out  1  sticky; set when a line had no row ready.
- dropped  out  1  sticky; set when rp_valid arrived while the back buffer was full.

## Operation
- Counters:
  - hcnt counts 0..H_TOTAL-1, where H_TOTAL = 800.
  - vcnt counts 0..V_TOTAL-1, where V_TOTAL = 525.
  - hcnt increments on clk_en. At wrap it returns to 0 and vcnt increments; vcnt wraps to 0.
- Reset state:
  - hcnt = H_TOTAL-1, vcnt = V_TOTAL-1, so the first tick performs the swap for line 0.
  - Both buffers cleared; back_full = 0.
  - Outputs: pix_on = 0, de = 0, hsync = 1, vsync = 1, frame_start = 0, underrun = 0, dropped = 0, row_req = 0.
- row_req = !back_full. It is registered, so it reads 1 from the first cycle after reset deassertion.
- Capture:
  - rp_valid with back_full = 0 loads back <= mg_mask and sets back_full = 1.
  - rp_valid with back_full = 1 discards the row, sets dropped, and leaves back unchanged.
  - Capture is independent of clk_en.
- Swap:
  - A swap occurs on clk_en && hcnt == H_TOTAL-1 && next vcnt < V_ACTIVE.
  - If back_full: front <= back, back_full <= 0.
  - Otherwise: front <= 0 (blank line) and underrun is set.
  - For the line 0 swap, frame_start pulses for that single cycle.
- Simultaneous rp_valid and swap with back_full = 0: the incoming mg_mask bypasses into front, back_full stays 0, and underrun is not set.
- Simultaneous rp_valid and swap with back_full = 1: back moves to front and the incoming row loads into back. back_full stays 1 and dropped is not set.
- Pixel path: when hcnt < H_ACTIVE and vcnt < V_ACTIVE, pix_on = front[hcnt] and de = 1. Otherwise pix_on = 0 and de = 0.
- Sync:
  - hsync = 0 when hcnt is in [656, 751].
  - vsync = 0 when vcnt is in [490, 491].
- Reset mid-frame: returns to the reset state on the next edge. Any partially delivered row is lost; no underrun is flagged.
- underrun and dropped clear only on rst.

## Timing
- All outputs are registered. On a clk_en edge, pix_on, de, hsync and vsync reflect the pre-increment hcnt/vcnt. They therefore lag the counters by 1 clk.
- When clk_en = 0, pix_on, de, hsync and vsync hold their values; frame_start is 0.
- Row deadline: rp_valid must occur at or before the swap edge of the target line.
- The earliest next-row window opens 1 cycle after a swap, when row_req rises.
- Capture to row_req deassertion: 1 clk.
- Pixel x of line y appears on pix_on after the clk_en edge where hcnt = x, vcnt = y.

## Structure
- Package vga_timing_pkg holds:
  - localparams for the 640x480 timing: the porch/sync defaults plus H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
  - typedefs hcnt_t (logic [9:0]) and vcnt_t (logic [9:0]).
- Sub-module vga_timing_gen contains the counters, sync/de decode and the line_swap strobe.
- mask_scanout_vga contains the buffers, the capture/swap logic, the sticky flags and the output registers.

## Test plan
- Reset, then send rp_valid with mg_mask = {1'b1, 639'b0} before the first swap. Required: line 0 shows pix_on = 1 only at hcnt 0; de is high for 640 ticks; no underrun.
- Run a full frame with clk_en = 1 and a row sent on every row_req. Required: hsync low for 96 ticks starting at hcnt 656; vsync low for lines 490–491; frame_start pulses once every 420000 clk.
- Withhold the row for line 5. Required: line 5 pix_on is all 0 and underrun = 1. Line 6 displays its row normally.
- Send two rp_valid strobes back-to-back while back_full. Required: the second row is discarded, dropped = 1, and the first row is displayed.
- Drive rp_valid on the swap edge with back_full = 0, using pattern 0xAA repeated. Required: that line displays alternating 1/0 and underrun stays 0.
- Hold clk_en at 1 tick in 3. Required: the output waveforms are identical per tick, and row_req rises 1 clk after the swap. Then assert rst at line 200: all outputs return to their reset values on the next edge.
